// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF response framer.
// Holds the framer state encoding, the default header byte and the frame-length helper.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    FIN
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Header + channel ID + payload bytes + optional checksum byte.
  function automatic int frame_len(input int resp_w, input int chk_en);
    return resp_w / 8 + 2 + chk_en;
  endfunction

endpackage

// File: rtl/puf_byte_sel.sv
// Combinational picker returning payload byte idx of the captured response.
// Byte 0 is the most significant byte when MSB_FIRST is set, otherwise the least significant.
module puf_byte_sel #(
  parameter int RESP_W    = 256,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = 6
) (
  input  logic [RESP_W-1:0] shadow,
  input  logic [IDX_W-1:0]  idx,
  output logic [7:0]        byte_out
);

  localparam int NB = RESP_W / 8;

  always_comb begin
    byte_out = '0;
    for (int b = 0; b < NB; b++) begin
      if (((MSB_FIRST != 0) ? (NB - 1 - b) : b) == int'(idx)) begin
        byte_out = shadow[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/puf_resp_framer.sv
// Frames one PUF response as HDR, channel ID, payload bytes and an optional XOR checksum,
// handing bytes to uart_tx one at a time under the tx_dv / uart_done handshake.
module puf_resp_framer
  import puf_pkg::*;
#(
  parameter int         RESP_W    = 256,
  parameter int         CHAN      = 2,
  parameter logic [7:0] HDR       = HDR_DEFAULT,
  parameter int         CHK_EN    = 1,
  parameter int         MSB_FIRST = 1,
  localparam int        SEL_W     = (CHAN > 1) ? $clog2(CHAN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHAN*RESP_W-1:0] resp,
  input  logic [CHAN-1:0]        resp_dv,
  input  logic [SEL_W-1:0]       sel,
  output logic [7:0]             tx_byte,
  output logic                   tx_dv,
  input  logic                   uart_done,
  output logic                   busy,
  output logic                   done,
  output logic                   dropped
);

  localparam int               N     = frame_len(RESP_W, CHK_EN);
  localparam int               IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  state_t            state;
  logic [RESP_W-1:0] shadow;
  logic [RESP_W-1:0] resp_sel;
  logic [SEL_W-1:0]  chan_id;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [IDX_W-1:0]  pay_idx;
  logic [7:0]        chk;
  logic [7:0]        pay_byte;
  logic [7:0]        nxt_byte;
  logic [7:0]        id_byte;
  logic              dv_sel;

  always_comb begin
    dv_sel   = 1'b0;
    resp_sel = '0;
    for (int k = 0; k < CHAN; k++) begin
      if (sel == SEL_W'(k)) begin
        dv_sel   = resp_dv[k];
        resp_sel = resp[k*RESP_W +: RESP_W];
      end
    end
  end

  // tx_byte is registered, so the byte for the next SEND is chosen from idx+1 while in WAIT.
  assign nxt_idx = idx + IDX_W'(1);
  assign pay_idx = nxt_idx - IDX_W'(2);
  assign id_byte = 8'(chan_id);

  puf_byte_sel #(
    .RESP_W   (RESP_W),
    .MSB_FIRST(MSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_byte_sel (
    .shadow  (shadow),
    .idx     (pay_idx),
    .byte_out(pay_byte)
  );

  always_comb begin
    nxt_byte = pay_byte;
    if (nxt_idx == IDX_W'(1)) nxt_byte = id_byte;
    else if (CHK_EN != 0 && nxt_idx == LAST) nxt_byte = chk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_byte <= '0;
      tx_dv   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dropped <= 1'b0;
      shadow  <= '0;
      idx     <= '0;
    end else begin
      tx_dv   <= 1'b0;
      done    <= 1'b0;
      dropped <= dv_sel && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (dv_sel) begin
            shadow  <= resp_sel;
            chan_id <= sel;
            idx     <= '0;
            chk     <= '0;
            tx_byte <= HDR;
            tx_dv   <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          // Header and the checksum byte itself stay out of the running XOR.
          if (idx != '0 && !(CHK_EN != 0 && idx == LAST)) chk <= chk ^ tx_byte;
          state <= WAIT;
        end
        WAIT: begin
          if (uart_done) begin
            if (idx == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              idx     <= nxt_idx;
              tx_byte <= nxt_byte;
              tx_dv   <= 1'b1;
              state   <= SEND;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_resp_framer.md
# puf_resp_framer

Parametrised response framer between the PUF response sources (raw PUF, error-corrected, SHA-256 digest) and `uart_tx`. It generalises the fixed 256-bit, two-source response path to CHAN sources of RESP_W bits. Each response is sent as a framed byte stream: header, channel ID, payload, and an optional XOR checksum. The bytes go out one at a time under the `tx_dv`/`uart_done` handshake.

## Interface
- RESP_W, 256, response width in bits; must be a multiple of 8, ≥ 8
- CHAN, 2, number of response sources, 1..16
- HDR, 8'hA5, frame header byte
- CHK_EN, 1, 1 = append XOR checksum byte
- MSB_FIRST, 1, 1 = payload byte [RESP_W-1:RESP_W-8] first; 0 = byte [7:0] first
- clk  in  1  single clock (10 MHz domain)
- reset  in  1  reset is synchronous and active-high
- resp  in  CHAN*RESP_W  response of channel k at [k*RESP_W +: RESP_W]
- resp_dv  in  CHAN  per-channel one-cycle valid pulse
- sel  in  max(1,$clog2(CHAN))  channel currently enabled; only resp_dv[sel] is accepted
- tx_byte  out  8  byte to uart_tx
- tx_dv  out  1  one-cycle strobe, tx_byte valid
- uart_done  in  1  one-cycle pulse from uart_tx, byte finished
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- dropped  out  1  one-cycle pulse, accepted-channel dv arrived while busy

## Operation
- Frame length N = RESP_W/8 + 2 + CHK_EN bytes: HDR, channel ID (zero-extended sel), payload bytes, then checksum if enabled.
- Checksum = XOR of the channel ID and all payload bytes. HDR is excluded.
- States:
  - IDLE: waits for resp_dv[sel].
  - SEND: drives tx_dv for one cycle.
  - WAIT: waits for uart_done.
  - FIN: pulses done.
- IDLE → SEND: on resp_dv[sel] = 1. The same edge captures resp[sel] into the shadow register, captures the channel ID, clears the byte index and checksum, and sets busy = 1.
- SEND → WAIT: always, after one cycle. tx_dv = 1 and tx_byte = current byte while in SEND; the checksum accumulates at this point.
- WAIT → SEND: on uart_done when byte index < N-1; the index then increments.
- WAIT → FIN: on uart_done when byte index = N-1.
- FIN → IDLE: always. done = 1 for this one cycle; busy = 0 from the FIN cycle onward.
- Any resp_dv[sel] outside IDLE pulses dropped and is otherwise ignored. FIN counts as busy.
- resp_dv on channels other than sel is ignored, with no dropped pulse.
- sel is sampled only at the capture edge. Changes during a frame have no effect.
- uart_done outside WAIT is ignored.
- Reset values: state IDLE, tx_byte 0, tx_dv 0, busy 0, done 0, dropped 0, shadow register and index 0.
- Reset mid-frame aborts immediately: tx_dv = 0 on the next edge, and no done pulse is issued.

## Timing
- Capture edge t: tx_dv goes high for cycle t+1 with HDR.
- uart_done sampled high at edge u: the next tx_dv goes high for cycle u+1.
- The last uart_done, at edge u: done and busy=0 in cycle u+1, IDLE at u+2. A new resp_dv is accepted at edge u+2.
- tx_dv is never high on two consecutive cycles.
- At most one tx_dv per uart_done.
- Minimum frame time is 2N+1 cycles with zero-latency uart_done.

## Structure
- Shared package `puf_pkg`:
  - state enum (IDLE, SEND, WAIT, FIN)
  - default HDR constant
  - function `frame_len(RESP_W, CHK_EN)`
- One sub-module, `puf_byte_sel`: combinational picker that returns payload byte i of the shadow register, honouring MSB_FIRST.
- Byte-index width is $clog2(N).

## Test plan
- RESP_W=16, CHAN=2, MSB_FIRST=1, sel=1, resp ch1=16'h1234, dv pulse → tx bytes A5,01,12,34,27; done one cycle after the fifth uart_done.
- Same setup with MSB_FIRST=0 → bytes A5,01,34,12,27.
- Same setup with CHK_EN=0 → exactly 4 bytes A5,01,12,34; no fifth tx_dv.
- sel=0, pulse resp_dv[1] → no tx_dv and no dropped. Then a resp_dv[1] with sel=1 and uart_done held 20 cycles per byte; a second dv mid-frame → one dropped pulse and an unchanged byte stream.
- Assert reset after the second byte → tx_dv, busy, done all 0 next cycle. A new frame after release starts with A5.
- Default params, resp=256'h01..20 (bytes 0x01–0x20 ascending from MSB), sel=0 → 35 bytes; checksum = 0x00 ^ XOR(0x01..0x20) = 0x20; stray uart_done in IDLE → ignored.
